lc3b_mem_port: RTL

- Parametrised memory-port unit for the multi-cycle LC-3b core and its wider successors; replaces the loose MAR/MDR register pair with a self-contained sequenced block.
- The core sees a simple request/response interface: one outstanding request at a time.
- The unit drives the memory read/write/resp handshake, registers address and data (MAR/MDR), steers byte lanes for byte accesses, and flags misaligned word accesses.

---
 rtl/lc3b_mem_port.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lc3b_mem_port.sv
// Sequenced memory port for the multi-cycle LC-3b core: MAR/MDR, byte-lane steering, misalign flag.
// Optional `MEM_TIMEOUT_EN` adds an ACCESS watchdog that ends a stalled access with an error response.
module lc3b_mem_port #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    localparam int LANES  = DATA_W / 8,
    localparam int LSB_W  = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [LANES-1:0]  mem_byte_enable,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // ACCESS | memory strobe asserted until mem_resp (or watchdog expiry)
    // RESP   | one-cycle response strobe to the core
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    if (DATA_W < 16 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_width
        $error("lc3b_mem_port: DATA_W must be a power of two and at least 16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lc3b_mem_port: TIMEOUT must be at least 1");
    end

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [LANES-1:0]  be_q;
    logic [LSB_W-1:0]  lane_q;
    logic              wr_q;
    logic              byte_q;
    logic              err_q;
    logic              tmo;

    logic [LSB_W-1:0]  req_lane;
    logic              misaligned;
    logic [LANES-1:0]  lane_onehot;
    logic [7:0]        lane_byte;

    assign req_lane    = req_addr[LSB_W-1:0];
    assign misaligned  = !req_byte && (req_lane != '0);
    assign lane_onehot = LANES'(1) << req_lane;
    assign lane_byte   = mdr[{lane_q, 3'b000} +: 8];

`ifdef MEM_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TMR_W-1:0] timer;

    // Cleared whenever not in ACCESS, so every access starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == S_ACCESS) begin
            timer <= timer + TMR_W'(1);
        end else begin
            timer <= '0;
        end
    end

    // A mem_resp in the expiry cycle takes priority over the timeout.
    assign tmo = (state == S_ACCESS) && !mem_resp && (timer == TMR_W'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_resp || tmo) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar    <= '0;
            mdr    <= '0;
            be_q   <= '0;
            lane_q <= '0;
            wr_q   <= 1'b0;
            byte_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b0;
                            mar    <= {req_addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                            wr_q   <= req_write;
                            byte_q <= req_byte;
                            lane_q <= req_lane;
                            if (!req_write) begin
                                be_q <= '0;
                                mdr  <= '0;
                            end else if (req_byte) begin
                                be_q <= lane_onehot;
                                mdr  <= {LANES{req_wdata[7:0]}};
                            end else begin
                                be_q <= '1;
                                mdr  <= req_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem_resp && !wr_q) begin
                        mdr <= mem_rdata;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready       = (state == S_IDLE);
        rsp_valid       = (state == S_RESP);
        rsp_err         = (state == S_RESP) && err_q;
        mem_read        = (state == S_ACCESS) && !wr_q;
        mem_write       = (state == S_ACCESS) && wr_q;
        mem_address     = mar;
        mem_wdata       = mdr;
        mem_byte_enable = mem_write ? be_q : '0;
        rsp_rdata       = '0;
        if ((state == S_RESP) && !err_q && !wr_q) begin
            rsp_rdata = byte_q ? {{(DATA_W-8){1'b0}}, lane_byte} : mdr;
        end
    end

endmodule
